// File: rtl/ysyx_25020047_pkg.sv
// Shared sequencer state encoding and decoder instruction-class codes.
// inst_type codes are one-hot, except the all-ones code for an illegal instruction.
package ysyx_25020047_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_HALT   = 3'd6,
      S_ERROR  = 3'd7
   } state_e;

   localparam logic [31:0] TYPE_EBREAK  = 32'h0000_0004;
   localparam logic [31:0] TYPE_LW      = 32'h0000_0020;
   localparam logic [31:0] TYPE_LBU     = 32'h0000_0040;
   localparam logic [31:0] TYPE_SW      = 32'h0000_0080;
   localparam logic [31:0] TYPE_SB      = 32'h0000_0100;
   localparam logic [31:0] TYPE_BEQ     = 32'h0000_4000;
   localparam logic [31:0] TYPE_BNE     = 32'h0000_8000;
   localparam logic [31:0] TYPE_ILLEGAL = 32'hFFFF_FFFF;

   function automatic logic is_load(input logic [31:0] t);
      return (t == TYPE_LW) || (t == TYPE_LBU);
   endfunction

   function automatic logic is_store(input logic [31:0] t);
      return (t == TYPE_SW) || (t == TYPE_SB);
   endfunction

   function automatic logic is_branch(input logic [31:0] t);
      return (t == TYPE_BEQ) || (t == TYPE_BNE);
   endfunction

endpackage

// File: rtl/ysyx_25020047_wait_timer.sv
// Memory-response watchdog: 16-bit saturating wait counter.
// Latency: expired is combinational from the registered count and en.
// Backpressure: none; clr dominates en.
module ysyx_25020047_wait_timer #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   // expired flags the wait cycle whose increment would bring the count to TIMEOUT
   localparam logic [15:0] LIMIT = 16'(TIMEOUT - 1);

   logic [15:0] cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en && (cnt != 16'hFFFF)) begin
         cnt <= cnt + 16'd1;
      end
   end

   assign expired = en && (cnt == LIMIT);

endmodule

// File: rtl/ysyx_25020047_core_seq.sv
// Multi-cycle fetch/decode/exec/mem/wb sequencer with ebreak halt and memory watchdog.
// Latency: 4 cycles per non-memory instruction, 5 for load/store, +1 per memory wait cycle.
// Backpressure: imem_req/dmem_req held until response; watchdog traps to ERROR on timeout.
module ysyx_25020047_core_seq
   import ysyx_25020047_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic        imem_req,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] inst_q,
   input  logic [31:0] inst_type,
   output logic        dmem_req,
   output logic        dmem_wen,
   input  logic        dmem_ack,
   output logic        reg_wen,
   output logic        pc_wen,
   output logic        halt,
   output logic        err,
   output logic [2:0]  state,
   output logic [31:0] instret
);

   state_e state_q;
   logic   waiting;
   logic   resp;
   logic   expired;
   logic   gpr_write;

   assign state     = state_q;
   assign waiting   = (state_q == S_FETCH) || (state_q == S_MEM);
   assign resp      = ((state_q == S_FETCH) && imem_rvalid) || ((state_q == S_MEM) && dmem_ack);
   assign gpr_write = !(is_store(inst_type) || is_branch(inst_type));

   // Counter is held clear outside FETCH/MEM, so every entry starts from zero
   ysyx_25020047_wait_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_wait_timer (
      .clk     (clk),
      .rst     (rst),
      .clr     (!waiting || resp),
      .en      (waiting && !resp),
      .expired (expired)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         inst_q   <= '0;
         instret  <= '0;
         imem_req <= 1'b0;
         dmem_req <= 1'b0;
         dmem_wen <= 1'b0;
         reg_wen  <= 1'b0;
         pc_wen   <= 1'b0;
         halt     <= 1'b0;
         err      <= 1'b0;
      end else begin
         // Moore outputs are computed for the state being entered
         imem_req <= 1'b0;
         dmem_req <= 1'b0;
         dmem_wen <= 1'b0;
         reg_wen  <= 1'b0;
         pc_wen   <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_q  <= S_FETCH;
                  imem_req <= 1'b1;
               end
            end
            S_FETCH: begin
               if (imem_rvalid) begin
                  inst_q  <= imem_rdata;
                  state_q <= S_DECODE;
               end else if (expired) begin
                  state_q <= S_ERROR;
                  err     <= 1'b1;
               end else begin
                  imem_req <= 1'b1;
               end
            end
            S_DECODE: begin
               state_q <= S_EXEC;
            end
            S_EXEC: begin
               if (inst_type == TYPE_EBREAK) begin
                  state_q <= S_HALT;
                  halt    <= 1'b1;
               end else if (inst_type == TYPE_ILLEGAL) begin
                  state_q <= S_ERROR;
                  err     <= 1'b1;
               end else if (is_load(inst_type) || is_store(inst_type)) begin
                  state_q  <= S_MEM;
                  dmem_req <= 1'b1;
                  dmem_wen <= is_store(inst_type);
               end else begin
                  state_q <= S_WB;
                  pc_wen  <= 1'b1;
                  reg_wen <= gpr_write;
               end
            end
            S_MEM: begin
               if (dmem_ack) begin
                  state_q <= S_WB;
                  pc_wen  <= 1'b1;
                  reg_wen <= gpr_write;
               end else if (expired) begin
                  state_q <= S_ERROR;
                  err     <= 1'b1;
               end else begin
                  dmem_req <= 1'b1;
                  dmem_wen <= dmem_wen;
               end
            end
            S_WB: begin
               instret  <= instret + 32'd1;
               state_q  <= S_FETCH;
               imem_req <= 1'b1;
            end
            S_HALT: begin
               state_q <= S_HALT;
            end
            S_ERROR: begin
               state_q <= S_ERROR;
            end
            default: begin
               state_q <= S_ERROR;
               err     <= 1'b1;
            end
         endcase
      end
   end

endmodule
